// File: rtl/mdu_hilo_unit_if.sv
// rtl/mdu_hilo_unit_if.sv - EX-stage bus between the pipeline and the HI/LO multiply/divide unit
//
// Signals:
//   valid_in   EX slot holds a live instruction
//   flush      kills the current operation, no HI/LO write this cycle
//   funct      normalised funct code (SPECIAL funct or remapped FUNCT2_*)
//   operand_a  rs value
//   operand_b  rt value
//   stall_req  holds IF/ID/EX while a division is running
//   hi_out     current HI register
//   lo_out     current LO register
//   div_busy   divider state machine is not idle
// Modports: master = pipeline side, slave = mdu_hilo_unit side.

interface mdu_hilo_unit_if;
  logic        valid_in;
  logic        flush;
  logic [5:0]  funct;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        stall_req;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_busy;

  modport master (
    output valid_in, flush, funct, operand_a, operand_b,
    input  stall_req, hi_out, lo_out, div_busy
  );

  modport slave (
    input  valid_in, flush, funct, operand_a, operand_b,
    output stall_req, hi_out, lo_out, div_busy
  );
endinterface

// File: rtl/mdu_hilo_unit.sv
// rtl/mdu_hilo_unit.sv - execute-stage multiply/divide unit owning the HI/LO registers
//
// Ports:
//   clk    pipeline clock
//   rst_n  asynchronous active-low reset
//   bus    mdu_hilo_unit_if.slave: valid_in, flush, funct, operand_a, operand_b in;
//          stall_req, hi_out, lo_out, div_busy out
// Parameters:
//   DIV_ITERS  quotient bits produced by the divider; equals the operand width (32)
// Optional build macro:
//   MDU_SPECIAL2_EN  adds MADD/MADDU/MSUB/MSUBU 64-bit accumulate into {HI,LO}
//
// Multiplies and HI/LO moves complete at the accepting edge. Division is
// radix-2 restoring: accept -> DIV (DIV_ITERS cycles) -> FIX (sign fix-up and
// HI/LO write) -> IDLE.

module mdu_hilo_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mdu_hilo_unit_if.slave  bus
);

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
`ifdef MDU_SPECIAL2_EN
  // SPECIAL2 ops are remapped by decode into codes unused by SPECIAL
  localparam logic [5:0] FUNCT2_MADD  = 6'h1C;
  localparam logic [5:0] FUNCT2_MADDU = 6'h1D;
  localparam logic [5:0] FUNCT2_MSUB  = 6'h1E;
  localparam logic [5:0] FUNCT2_MSUBU = 6'h1F;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam int CNT_W = $clog2(DIV_ITERS + 1);

  logic [1:0]       state;
  logic [31:0]      hi, lo;
  logic [31:0]      rem, quo, dvsr;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r, dbz;

  logic        accept;
  logic        is_div;
  logic        sgn_op;
  logic [31:0] a_abs, b_abs;
  logic [63:0] mul_a, mul_b, product;
  logic [32:0] rem_shift, trial;
  logic        trial_ok;
  logic [31:0] rem_next, quo_next;
  logic [31:0] q_fix, r_fix;

  assign accept = bus.valid_in && !bus.flush && (state == ST_IDLE);
  assign is_div = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);

`ifdef MDU_SPECIAL2_EN
  assign sgn_op = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV) ||
                  (bus.funct == FUNCT2_MADD) || (bus.funct == FUNCT2_MSUB);
`else
  assign sgn_op = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
`endif

  // Low 64 bits of the product of sign- or zero-extended operands give the
  // signed or unsigned 32x32 product, so one multiplier serves both.
  assign mul_a   = sgn_op ? {{32{bus.operand_a[31]}}, bus.operand_a} : {32'd0, bus.operand_a};
  assign mul_b   = sgn_op ? {{32{bus.operand_b[31]}}, bus.operand_b} : {32'd0, bus.operand_b};
  assign product = mul_a * mul_b;

`ifdef MDU_SPECIAL2_EN
  logic        acc_sub;
  logic [63:0] hilo_acc;
  assign acc_sub  = (bus.funct == FUNCT2_MSUB) || (bus.funct == FUNCT2_MSUBU);
  assign hilo_acc = acc_sub ? ({hi, lo} - product) : ({hi, lo} + product);
`endif

  // Magnitudes for signed division; -0x80000000 wraps to itself, which is the
  // correct unsigned magnitude.
  assign a_abs = (sgn_op && bus.operand_a[31]) ? (32'd0 - bus.operand_a) : bus.operand_a;
  assign b_abs = (sgn_op && bus.operand_b[31]) ? (32'd0 - bus.operand_b) : bus.operand_b;

  // quo starts as the dividend and shifts its MSB into the partial remainder
  // while quotient bits shift in from the bottom.
  assign rem_shift = {rem, quo[31]};
  assign trial     = rem_shift - {1'b0, dvsr};
  assign trial_ok  = !trial[32];
  assign rem_next  = trial_ok ? trial[31:0] : rem_shift[31:0];
  assign quo_next  = {quo[30:0], trial_ok};

  assign q_fix = neg_q ? (32'd0 - quo) : quo;
  assign r_fix = neg_r ? (32'd0 - rem) : rem;

  assign bus.stall_req = (accept && is_div) || ((state == ST_DIV) && !bus.flush);
  assign bus.div_busy  = (state != ST_IDLE);
  assign bus.hi_out    = hi;
  assign bus.lo_out    = lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      hi    <= '0;
      lo    <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (bus.funct)
              FUNCT_MULT, FUNCT_MULTU: {hi, lo} <= product;
              FUNCT_MTHI: hi <= bus.operand_a;
              FUNCT_MTLO: lo <= bus.operand_a;
              FUNCT_MFHI, FUNCT_MFLO: ;  // reads come straight from hi_out/lo_out
`ifdef MDU_SPECIAL2_EN
              FUNCT2_MADD, FUNCT2_MADDU,
              FUNCT2_MSUB, FUNCT2_MSUBU: {hi, lo} <= hilo_acc;
`endif
              FUNCT_DIV, FUNCT_DIVU: begin
                quo   <= a_abs;
                dvsr  <= b_abs;
                rem   <= '0;
                cnt   <= CNT_W'(DIV_ITERS);
                neg_q <= sgn_op && (bus.operand_a[31] ^ bus.operand_b[31]);
                neg_r <= sgn_op && bus.operand_a[31];
                dbz   <= (bus.operand_b == 32'd0);
                // Divide by zero skips the iterations; FIX then writes nothing.
                state <= (bus.operand_b == 32'd0) ? ST_FIX : ST_DIV;
              end
              default: ;
            endcase
          end
        end
        ST_DIV: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!bus.flush && !dbz) begin
            lo <= q_fix;
            hi <= r_fix;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// tb/tb_mdu_hilo_unit.sv - self-checking bench for mdu_hilo_unit with an expected-HI/LO scoreboard

module tb_mdu_hilo_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MADDU = 6'h1D;
  localparam logic [5:0] F_MSUB  = 6'h1E;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_hilo_unit_if bus();

  mdu_hilo_unit #(.DIV_ITERS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model = 64'd0;  // expected {HI,LO}

  // Drives one operation at the current negedge, samples stall_req mid-cycle,
  // and returns at the next negedge after the accepting edge.
  task automatic single_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output logic st);
    bus.valid_in  = 1'b1;
    bus.funct     = f;
    bus.operand_a = a;
    bus.operand_b = b;
    #1 st = bus.stall_req;
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  // Runs a division from the current negedge until stall_req drops (FIX),
  // scrambling operands during the stall. Bounded to 60 cycles.
  task automatic run_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit flush_fix, output int nstall, output logic busy_fix);
    nstall = 0;
    busy_fix = 1'b0;
    bus.valid_in  = 1'b1;
    bus.funct     = f;
    bus.operand_a = a;
    bus.operand_b = b;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (!bus.stall_req) begin
        busy_fix = bus.div_busy;
        if (flush_fix) bus.flush = 1'b1;
        break;
      end
      nstall++;
      @(negedge clk);
      bus.valid_in  = 1'b0;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
    end
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    bus.valid_in = 1'b0; bus.flush = 1'b0; bus.funct = 6'd0;
    bus.operand_a = 32'd0; bus.operand_b = 32'd0;
    #2;
    vectors++;
    if ({bus.hi_out, bus.lo_out} !== 64'd0) begin
      miscompares++; $display("FAIL reset_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, 64'd0);
    end
    vectors++;
    if (bus.stall_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: got %b want 0", bus.stall_req);
    end
    vectors++;
    if (bus.div_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b want 0", bus.div_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    logic st;
    logic [63:0] e;
    single_op(F_MULT, 32'hFFFFFFFD, 32'd5, st);
    model = 64'hFFFFFFFF_FFFFFFF1; exp_q.push_back(model);
    vectors++;
    if (st !== 1'b0) begin miscompares++; $display("FAIL mult_stall: got %b want 0", st); end
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL mult_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
    single_op(F_MULTU, 32'hFFFFFFFD, 32'd5, st);
    model = 64'h00000004_FFFFFFF1; exp_q.push_back(model);
    vectors++;
    if (st !== 1'b0) begin miscompares++; $display("FAIL multu_stall: got %b want 0", st); end
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL multu_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
  endtask

  task automatic test_divu();
    int n;
    logic bf;
    logic [63:0] e;
    run_div(F_DIVU, 32'd100, 32'd7, 1'b0, n, bf);
    model = {32'd2, 32'd14}; exp_q.push_back(model);
    vectors++;
    if (n !== 33) begin miscompares++; $display("FAIL divu_stall_cycles: got %0d want 33", n); end
    vectors++;
    if (bf !== 1'b1) begin miscompares++; $display("FAIL divu_busy_in_fix: got %b want 1", bf); end
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL divu_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
    vectors++;
    if (bus.div_busy !== 1'b0) begin miscompares++; $display("FAIL divu_busy_after: got %b want 0", bus.div_busy); end
  endtask

  task automatic test_div_signed();
    int n;
    logic bf;
    logic [63:0] e;
    int sa, sb, q, r;
    logic [31:0] ua, ub;
    run_div(F_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, n, bf);
    model = {32'hFFFFFFFF, 32'hFFFFFFFD}; exp_q.push_back(model);
    vectors++;
    if (n !== 33) begin miscompares++; $display("FAIL div_neg_stall_cycles: got %0d want 33", n); end
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL div_neg_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
    run_div(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, n, bf);
    model = {32'h0, 32'h80000000}; exp_q.push_back(model);
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL div_wrap_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
    for (int k = 0; k < 3; k++) begin
      sa = int'($urandom);
      sb = int'($urandom_range(2, 100000));
      if (k == 1) sb = -sb;
      q = sa / sb;
      r = sa % sb;
      ua = q; ub = r;
      run_div(F_DIV, sa, sb, 1'b0, n, bf);
      model = {ub, ua}; exp_q.push_back(model);
      e = exp_q.pop_front(); vectors++;
      if ({bus.hi_out, bus.lo_out} !== e) begin
        miscompares++;
        $display("FAIL div_rand_hilo: a=%h b=%h got %h want %h", sa, sb, {bus.hi_out, bus.lo_out}, e);
      end
    end
  endtask

  task automatic test_div_zero();
    logic st;
    int n;
    logic bf;
    logic [63:0] e;
    single_op(F_MTHI, 32'h11, 32'h0, st);
    single_op(F_MTLO, 32'h22, 32'h0, st);
    model = {32'h11, 32'h22}; exp_q.push_back(model);
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL mthi_mtlo_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
    run_div(F_DIV, 32'd9, 32'd0, 1'b0, n, bf);
    exp_q.push_back(model);
    vectors++;
    if (n !== 1) begin miscompares++; $display("FAIL divzero_stall_cycles: got %0d want 1", n); end
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL divzero_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
    vectors++;
    if (bus.div_busy !== 1'b0) begin miscompares++; $display("FAIL divzero_busy_after: got %b want 0", bus.div_busy); end
  endtask

  task automatic test_flush();
    logic st;
    int n;
    logic bf;
    logic [63:0] e;
    bus.valid_in = 1'b1; bus.funct = F_DIVU; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    vectors++;
    if (bus.stall_req !== 1'b1) begin miscompares++; $display("FAIL flush_pre_stall: got %b want 1", bus.stall_req); end
    bus.flush = 1'b1;
    #1;
    vectors++;
    if (bus.stall_req !== 1'b0) begin miscompares++; $display("FAIL flush_stall_drop: got %b want 0", bus.stall_req); end
    @(negedge clk);
    bus.flush = 1'b0;
    exp_q.push_back(model);
    vectors++;
    if (bus.div_busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy: got %b want 0", bus.div_busy); end
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL flush_div_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
    single_op(F_MULT, 32'd2, 32'd3, st);
    model = {32'd0, 32'd6}; exp_q.push_back(model);
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL mult_after_flush_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
    bus.flush = 1'b1;
    single_op(F_MULT, 32'd7, 32'd7, st);
    bus.flush = 1'b0;
    exp_q.push_back(model);
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL flush_accept_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
    run_div(F_DIVU, 32'd100, 32'd7, 1'b1, n, bf);
    exp_q.push_back(model);
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL flush_fix_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
  endtask

  task automatic test_special2();
    logic st;
    logic [63:0] e;
    single_op(F_MTHI, 32'h0, 32'h0, st);
    single_op(F_MTLO, 32'hFFFFFFFF, 32'h0, st);
    model = {32'h0, 32'hFFFFFFFF};
    single_op(F_MADDU, 32'd1, 32'd1, st);
`ifdef MDU_SPECIAL2_EN
    model = {32'h1, 32'h0};
`endif
    exp_q.push_back(model);
    vectors++;
    if (st !== 1'b0) begin miscompares++; $display("FAIL maddu_stall: got %b want 0", st); end
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL maddu_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
    single_op(F_MSUB, 32'd2, 32'd3, st);
`ifdef MDU_SPECIAL2_EN
    model = {32'h0, 32'hFFFFFFFA};
`endif
    exp_q.push_back(model);
    e = exp_q.pop_front(); vectors++;
    if ({bus.hi_out, bus.lo_out} !== e) begin
      miscompares++; $display("FAIL msub_hilo: got %h want %h", {bus.hi_out, bus.lo_out}, e);
    end
  endtask

  task automatic test_back_to_back();
    logic st;
    logic [63:0] e;
    logic [5:0] f;
    logic [31:0] a, b;
    longint sa, sb;
    longint unsigned ua, ub;
    for (int k = 0; k < 12; k++) begin
      a = $urandom; b = $urandom;
      case (k % 6)
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_MTHI;
        3: f = F_ADD;
        4: f = F_MTLO;
        default: f = F_MFHI;
      endcase
      single_op(f, a, b, st);
      if (f == F_MULT) begin
        sa = longint'(int'(a)); sb = longint'(int'(b));
        model = sa * sb;
      end else if (f == F_MULTU) begin
        ua = {32'd0, a}; ub = {32'd0, b};
        model = ua * ub;
      end else if (f == F_MTHI) begin
        model[63:32] = a;
      end else if (f == F_MTLO) begin
        model[31:0] = a;
      end
      exp_q.push_back(model);
      e = exp_q.pop_front(); vectors++;
      if ({bus.hi_out, bus.lo_out} !== e || st !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_op%0d f=%h: got %h stall %b want %h stall 0", k, f, {bus.hi_out, bus.lo_out}, st, e);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    logic st;
    single_op(F_MTHI, 32'h55, 32'h0, st);
    bus.valid_in = 1'b1; bus.funct = F_DIVU; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.div_busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_div_state: busy %b stall %b want 0 0", bus.div_busy, bus.stall_req);
    end
    vectors++;
    if ({bus.hi_out, bus.lo_out} !== 64'd0) begin
      miscompares++; $display("FAIL rst_mid_div_hilo: got %h want 0", {bus.hi_out, bus.lo_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    vectors++;
    if ({bus.hi_out, bus.lo_out} !== 64'd0 || bus.div_busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_div_after: hilo %h busy %b want 0 0", {bus.hi_out, bus.lo_out}, bus.div_busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_flush();
    test_special2();
    test_back_to_back();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
